// File: rtl/xnor_prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xnor_prbs_pkg
// Brief   : Shared states, tap constants and prediction helper for the
//           XNOR-LFSR PRBS checker.
// Revision: 1.0
// ============================================================================
package xnor_prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam logic [6:0]  PRBS7_TAPS  = 7'b1100000;
    localparam logic [14:0] PRBS15_TAPS = 15'b110000000000000;

    // Zero padding above the mask does not change an XNOR reduction.
    function automatic logic xnor_predict(input logic [31:0] masked);
        return ~^masked;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xnor_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : xnor_lfsr
// Brief   : Shift register with XNOR-feedback prediction; shifts in either
//           the received bit or its own prediction.
// Revision: 1.0
// ============================================================================
module xnor_lfsr
    import xnor_prbs_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = PRBS7_TAPS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             shift_en_i,
    input  logic             sel_p_i,
    input  logic             d_i,
    output logic [WIDTH-1:0] sr_o,
    output logic             p_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             w_p;
    logic             w_in;

    always_comb begin
        w_p  = xnor_predict(32'(sr_q & TAPS));
        w_in = sel_p_i ? w_p : d_i;
        sr_d = sr_q;
        if (shift_en_i) begin
            sr_d = {sr_q[WIDTH-2:0], w_in};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_o = sr_q;
    assign p_o  = w_p;

endmodule
`default_nettype wire

// File: rtl/xnor_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module  : xnor_prbs_checker
// Brief   : Self-synchronising serial PRBS checker with lock tracking and a
//           saturating error counter. Define XNOR_PRBS_BITCNT_EN to add the
//           BIT_CNT locked-bit counter output.
// Revision: 1.0
// ============================================================================
module xnor_prbs_checker
    import xnor_prbs_pkg::*;
#(
    parameter int               WIDTH        = 7,
    parameter logic [WIDTH-1:0] TAPS         = PRBS7_TAPS,
    parameter int               LOCK_COUNT   = 8,
    parameter int               UNLOCK_COUNT = 4,
    parameter int               ERR_WIDTH    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 D,
    input  logic                 CLR,
    output logic                 LOCK,
    output logic                 ERR,
    output logic [ERR_WIDTH-1:0] ERR_CNT
`ifdef XNOR_PRBS_BITCNT_EN
    ,
    output logic [31:0]          BIT_CNT
`endif
);

    localparam int FILL_W  = $clog2(WIDTH) + 1;
    localparam int MATCH_W = $clog2(LOCK_COUNT) + 1;
    localparam int MISS_W  = $clog2(UNLOCK_COUNT) + 1;

    state_e               state_q, state_d;
    logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic                 err_q, err_d;
    logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic                 w_shift_en;
    logic                 w_sel_p;
    logic [WIDTH-1:0]     w_sr;
    logic                 w_p;
    logic                 w_match;

    xnor_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .CLK        (CLK),
        .RST        (RST),
        .shift_en_i (w_shift_en),
        .sel_p_i    (w_sel_p),
        .d_i        (D),
        .sr_o       (w_sr),
        .p_o        (w_p)
    );

    assign w_match = (D == w_p);

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        w_shift_en  = 1'b0;
        w_sel_p     = 1'b0;

        if (EN) begin
            w_shift_en = 1'b1;
            unique case (state_q)
                SEARCH: begin
                    if (fill_cnt_q == FILL_W'(WIDTH - 1)) begin
                        state_d     = ACQUIRE;
                        fill_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
                ACQUIRE: begin
                    // An all-ones register predicts 1 forever, so matches there prove nothing.
                    if (w_match && !(&w_sr)) begin
                        if (match_cnt_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    w_sel_p = 1'b1;
                    if (!w_match) begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (miss_cnt_q == MISS_W'(UNLOCK_COUNT - 1)) begin
                            state_d    = SEARCH;
                            fill_cnt_d = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        if (CLR) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= SEARCH;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign LOCK    = (state_q == LOCKED);
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;

`ifdef XNOR_PRBS_BITCNT_EN
    logic [31:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (EN && (state_q == LOCKED)) begin
            bit_cnt_d = bit_cnt_q + 32'd1;
        end
        if (CLR) begin
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign BIT_CNT = bit_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xnor_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_xnor_prbs_checker
// Brief   : Scoreboard bench for xnor_prbs_checker driven by an XNOR PRBS7
//           source with directed bit inversions, gaps, clears and resets.
// Revision: 1.0
// ============================================================================
module tb_xnor_prbs_checker;

    localparam int EW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          EN  = 1'b0;
    logic          D   = 1'b0;
    logic          CLR = 1'b0;
    logic          LOCK;
    logic          ERR;
    logic [EW-1:0] ERR_CNT;
`ifdef XNOR_PRBS_BITCNT_EN
    logic [31:0]   BIT_CNT;
`endif

    typedef struct packed {
        logic          lock;
        logic          err;
        logic [EW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks   = 0;
    int            failures = 0;
    logic [6:0]    gen_sr   = '0;
    logic [EW-1:0] e_cnt    = '0;

    always #5 CLK = ~CLK;

    xnor_prbs_checker #(
        .WIDTH        (7),
        .TAPS         (7'b1100000),
        .LOCK_COUNT   (8),
        .UNLOCK_COUNT (4),
        .ERR_WIDTH    (EW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .D       (D),
        .CLR     (CLR),
        .LOCK    (LOCK),
        .ERR     (ERR),
        .ERR_CNT (ERR_CNT)
`ifdef XNOR_PRBS_BITCNT_EN
        ,
        .BIT_CNT (BIT_CNT)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per clock edge, compared half a cycle later.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("lock",    32'(LOCK),    32'(mon_e.lock));
            check("err",     32'(ERR),     32'(mon_e.err));
            check("err_cnt", 32'(ERR_CNT), 32'(mon_e.cnt));
        end
    end

    // One EN cycle of the PRBS7 source; flip inverts the bit on the wire.
    task automatic send(input logic flip, input logic clr, input logic elock);
        logic b;
        b      = ~^(gen_sr & 7'b1100000);
        gen_sr = {gen_sr[5:0], b};
        EN     = 1'b1;
        D      = b ^ flip;
        CLR    = clr;
        if (clr) e_cnt = '0;
        else if (flip && (e_cnt != '1)) e_cnt = e_cnt + 1'b1;
        @(posedge CLK);
        sb.push_back('{elock, flip, e_cnt});
        #1;
        EN  = 1'b0;
        CLR = 1'b0;
    endtask

    task automatic idle(input logic elock);
        EN = 1'b0;
        D  = 1'($urandom);
        @(posedge CLK);
        sb.push_back('{elock, 1'b0, e_cnt});
        #1;
    endtask

    task automatic ones();
        EN = 1'b1;
        D  = 1'b1;
        @(posedge CLK);
        sb.push_back('{1'b0, 1'b0, 4'd0});
        #1;
        EN = 1'b0;
    endtask

    task automatic sync_reset();
        @(negedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST    = 1'b0;
        gen_sr = '0;
        e_cnt  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic lk;
        // Reset state
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst_lock", 32'(LOCK), 32'd0);
        check("rst_err",  32'(ERR),  32'd0);
        check("rst_cnt",  32'(ERR_CNT), 32'd0);
        RST = 1'b0;

        // Constant-1 stream must never lock
        for (int i = 0; i < 100; i++) ones();
        sync_reset();

        // Clean stream with a single error, a 4-bit burst, and CLR colliding with an error
        for (int k = 1; k <= 1000; k++) begin
            lk = (k >= 15) && !((k >= 403) && (k < 418));
            send((k == 200) || ((k >= 400) && (k <= 403)) || (k == 500) || (k == 600),
                 k == 500, lk);
        end

        // EN gaps with 20 isolated errors; counter saturates
        for (int j = 0; j < 80; j++) begin
            repeat ($urandom_range(0, 2)) idle(1'b1);
            send((j % 4) == 3, 1'b0, 1'b1);
        end
        send(1'b1, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);

        // Asynchronous reset while locked and ERR high
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("async_lock", 32'(LOCK),    32'd0);
        check("async_err",  32'(ERR),     32'd0);
        check("async_cnt",  32'(ERR_CNT), 32'd0);
`ifdef XNOR_PRBS_BITCNT_EN
        check("bit_cnt_rst", BIT_CNT, 32'd0);
`endif
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        e_cnt = '0;
        for (int k = 1; k <= 40; k++) send(1'b0, 1'b0, k >= 15);

        @(negedge CLK);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
